// File: rtl/detect_errors_2.sv
// Receive-side sequence checker: extracts a 16-bit aux sequence number from each
// frame, compares it with the expected value and keeps in-order/out-of-order/lost counts.
module detect_errors_2 #(
    parameter int unsigned whereis_aux = 0,
    parameter int unsigned maxaux      = 16,
    parameter int unsigned maxaux_bits = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] segment_number_max,
    input  logic [15:0] seg,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    output logic [31:0] count,
    output logic [31:0] ok,
    output logic [31:0] ng,
    output logic [31:0] lostnum,
    output logic        valid,
    output logic [2:0]  state
);

    localparam int unsigned SW     = maxaux_bits + 1;
    localparam int unsigned MOD    = maxaux + 1;
    localparam int unsigned HALF   = MOD / 2;
    localparam int unsigned LO_OFS = whereis_aux + 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECV     = 3'd1,
        WAIT_END = 3'd2,
        EVAL     = 3'd3,
        UPDATE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            rx_en_q;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]     aux_q, aux_d;
    logic [15:0]     seg_q, seg_d;
    logic [SW-1:0]   exp_q, exp_d;
    logic [SW-1:0]   diff_q, diff_d;
    logic            over_q, over_d;
    logic            synced_q, synced_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     ok_q, ok_d;
    logic [31:0]     ng_q, ng_d;
    logic [31:0]     lost_q, lost_d;
    logic            valid_q, valid_d;
    logic [SW-1:0]   aux_s;
    logic [SW-1:0]   aux_nxt;

    assign aux_s   = aux_q[SW-1:0];
    assign aux_nxt = (aux_s == SW'(maxaux)) ? '0 : aux_s + SW'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; only a fresh rx_en rise in IDLE opens a frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rx_en && !rx_en_q) state_d = RECV;
            RECV: begin
                if (!rx_en)                              state_d = IDLE;
                else if (byte_cnt_q == 16'(LO_OFS))      state_d = WAIT_END;
            end
            WAIT_END: if (!rx_en) state_d = EVAL;
            EVAL:     state_d = UPDATE;
            UPDATE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath and counter updates
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        aux_d      = aux_q;
        seg_d      = seg_q;
        exp_d      = exp_q;
        diff_d     = diff_q;
        over_d     = over_q;
        synced_d   = synced_q;
        count_d    = count_q;
        ok_d       = ok_q;
        ng_d       = ng_q;
        lost_d     = lost_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && !rx_en_q) begin
                    byte_cnt_d = 16'd1;
                    if (whereis_aux == 0) aux_d[15:8] = rx_data;
                end
            end
            RECV: begin
                if (rx_en) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (byte_cnt_q == 16'(whereis_aux)) aux_d[15:8] = rx_data;
                    if (byte_cnt_q == 16'(LO_OFS))      aux_d[7:0]  = rx_data;
                end
            end
            WAIT_END: if (!rx_en) seg_d = seg;
            EVAL: begin
                over_d = (aux_q > 16'(maxaux));
                // Modular distance; the wrap-around of the SW-bit sum is harmless
                if (aux_s >= exp_q) diff_d = aux_s - exp_q;
                else                diff_d = aux_s + SW'(MOD) - exp_q;
            end
            UPDATE: begin
                count_d = count_q + 32'd1;
                valid_d = (seg_q == segment_number_max - 16'd1);
                if (over_q) begin
                    ng_d = ng_q + 32'd1;
                end else begin
                    exp_d = aux_nxt;
                    if (!synced_q) begin
                        ok_d     = ok_q + 32'd1;
                        synced_d = 1'b1;
                    end else if (diff_q == '0) begin
                        ok_d = ok_q + 32'd1;
                    end else if (diff_q <= SW'(HALF)) begin
                        ng_d   = ng_q + 32'd1;
                        lost_d = lost_q + 32'(diff_q);
                    end else begin
                        ng_d = ng_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // rx_en history resets high so a frame already in flight at reset release is skipped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_en_q    <= 1'b1;
            byte_cnt_q <= '0;
            aux_q      <= '0;
            seg_q      <= '0;
            exp_q      <= '0;
            diff_q     <= '0;
            over_q     <= 1'b0;
            synced_q   <= 1'b0;
            count_q    <= '0;
            ok_q       <= '0;
            ng_q       <= '0;
            lost_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rx_en_q    <= rx_en;
            byte_cnt_q <= byte_cnt_d;
            aux_q      <= aux_d;
            seg_q      <= seg_d;
            exp_q      <= exp_d;
            diff_q     <= diff_d;
            over_q     <= over_d;
            synced_q   <= synced_d;
            count_q    <= count_d;
            ok_q       <= ok_d;
            ng_q       <= ng_d;
            lost_q     <= lost_d;
            valid_q    <= valid_d;
        end
    end

    assign count   = count_q;
    assign ok      = ok_q;
    assign ng      = ng_q;
    assign lostnum = lost_q;
    assign valid   = valid_q;
    assign state   = state_q;

endmodule

// File: tb/tb_detect_errors_2.sv
// Directed bench for detect_errors_2: in-order streams, gaps, late frames, runts, mid-frame reset.
module tb_detect_errors_2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] segment_number_max = 16'd5;
    logic [15:0] seg = 16'd0;
    logic        rx_en = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [31:0] count, ok, ng, lostnum;
    logic        valid;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;

    detect_errors_2 dut (
        .clk                (clk),
        .rst                (rst),
        .segment_number_max (segment_number_max),
        .seg                (seg),
        .rx_en              (rx_en),
        .rx_data            (rx_data),
        .count              (count),
        .ok                 (ok),
        .ng                 (ng),
        .lostnum            (lostnum),
        .valid              (valid),
        .state              (state)
    );

    always #4 clk = ~clk;

    always @(posedge clk) if (valid === 1'b1) vcnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [15:0] aux, input logic [15:0] s,
                              input int nbytes, input int gap);
        @(posedge clk); #1;
        seg = s;
        for (int i = 0; i < nbytes; i++) begin
            rx_en = 1'b1;
            if (i == 0)      rx_data = aux[15:8];
            else if (i == 5) rx_data = aux[7:0];
            else             rx_data = 8'(i * 7 + 3);
            @(posedge clk); #1;
        end
        rx_en   = 1'b0;
        rx_data = 8'd0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int c, input int o, input int n, input int l);
        @(negedge clk);
        chk({tag, "_count"}, count, 32'(c));
        chk({tag, "_ok"}, ok, 32'(o));
        chk({tag, "_ng"}, ng, 32'(n));
        chk({tag, "_lost"}, lostnum, 32'(l));
    endtask

    initial begin
        int fi;
        // reset state
        repeat (3) @(negedge clk);
        chk_all("rst", 0, 0, 0, 0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        rst = 1'b0;

        // in-order stream, wrapping at 16
        for (int i = 0; i < 89; i++) send_frame(16'(i % 17), 16'(i % 5), 33, 6);
        chk_all("t1", 89, 89, 0, 0);
        chk("t1_valid", 32'(vcnt), 32'd17);

        // four more rounds with long gaps, sequence continues
        for (int b = 1; b < 5; b++) begin
            repeat (80) @(posedge clk);
            for (int i = 0; i < 89; i++) begin
                fi = b * 89 + i;
                send_frame(16'(fi % 17), 16'(fi % 5), 33, 6);
            end
        end
        chk_all("t2", 445, 445, 0, 0);
        chk("t2_valid", 32'(vcnt), 32'd89);

        // gap of three frames, then back in order
        do_reset();
        for (int i = 0; i <= 5; i++) send_frame(16'(i), 16'd0, 33, 6);
        send_frame(16'd9, 16'd0, 33, 6);
        chk_all("t3_gap", 7, 6, 1, 3);
        send_frame(16'd10, 16'd0, 33, 6);
        chk_all("t3_resume", 8, 7, 1, 3);

        // late frame two back: no loss, expectation resyncs
        send_frame(16'd11, 16'd0, 33, 6);
        send_frame(16'd12, 16'd0, 33, 6);
        send_frame(16'd13, 16'd0, 33, 6);
        send_frame(16'd11, 16'd0, 33, 6);
        chk_all("t4_late", 12, 10, 2, 3);
        send_frame(16'd12, 16'd0, 33, 6);
        chk_all("t4_resync", 13, 11, 2, 3);

        // distance exactly M/2 counts as loss, M/2+1 does not
        send_frame(16'd4, 16'd0, 33, 6);
        chk_all("diff8", 14, 11, 3, 11);
        send_frame(16'd14, 16'd0, 33, 6);
        chk_all("diff9", 15, 11, 4, 11);
        send_frame(16'd15, 16'd0, 33, 6);
        // out-of-range aux leaves expectation at 16
        send_frame(16'd20, 16'd0, 33, 6);
        chk_all("over", 17, 12, 5, 11);
        send_frame(16'd16, 16'd0, 33, 6);
        chk_all("after_over", 18, 13, 5, 11);

        // runt frame is discarded
        send_frame(16'd0, 16'd0, 3, 6);
        chk_all("runt", 18, 13, 5, 11);
        chk("runt_state", 32'(state), 32'd0);

        // asynchronous reset in the middle of a frame
        @(posedge clk); #1;
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(i);
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 32'd0);
        chk("mid_rst_ok", ok, 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(16'd7, 16'd0, 33, 6);
        chk_all("post_rst", 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
